shift_iter_32: RTL

Multi-cycle shift sequencer for the ALU shift path. It accepts a 32-bit operand, a 5-bit shift amount and a shift opcode, then steps the existing one-bit right-shift stage once per clock until the requested distance is reached. Left shifts are performed as right shifts on a bit-reversed operand. The block sits between the ALU operand/decode logic, which issues `start`, and the one-bit stage, which it feeds and whose output it registers back. It trades latency (up to 33 cycles) for a single 32-bit mux row instead of a full barrel shifter.

---
 rtl/shift_pkg.sv | 20 ++
 rtl/shifter_32.sv | 18 +
 rtl/shift_iter_32.sv | 105 ++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared opcode and state encodings for the iterative shift sequencer.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_e;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

endpackage

// File: rtl/shifter_32.sv
// One-bit right-shift stage; arith supplies the bit shifted in at the MSB.
module shifter_32
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic              shamt,
    input  logic              arith,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = a;
        if (shamt) begin
            y = {arith, a[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/shift_iter_32.sv
// Multi-cycle shift sequencer: steps a one-bit right-shift stage once per clock.
// Left shifts run as right shifts on a bit-reversed operand.
//
// state | meaning
// IDLE  | waiting for start; result held on z
// SHIFT | one bit per cycle through the stage until cnt runs out
// DONE  | result captured into z; done pulses in the following cycle
module shift_iter_32
    import shift_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DATA_W-1:0]  x,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  z
);

    shift_state_e       state_q, state_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               fill_q, fill_d;
    logic [1:0]         op_q, op_d;
    logic [DATA_W-1:0]  z_q, z_d;
    logic               done_q, done_d;

    logic [DATA_W-1:0]  x_rev;
    logic [DATA_W-1:0]  acc_rev;
    logic [DATA_W-1:0]  stage_y;

    for (genvar i = 0; i < DATA_W; i++) begin : g_rev
        assign x_rev[i]   = x[DATA_W-1-i];
        assign acc_rev[i] = acc_q[DATA_W-1-i];
    end

    shifter_32 u_stage (
        .a     (acc_q),
        .shamt (1'b1),
        .arith (fill_q),
        .y     (stage_y)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        op_d    = op_q;
        z_d     = z_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = (op == OP_SLL) ? x_rev : x;
                    cnt_d   = shamt;
                    fill_d  = (op == OP_SRA) & x[DATA_W-1];
                    op_d    = op;
                    state_d = (shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                acc_d = stage_y;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                z_d     = (op_q == OP_SLL) ? acc_rev : acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
            op_q    <= 2'b00;
            z_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            op_q    <= op_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    // the done cycle counts as busy even though the FSM is already back in IDLE
    assign busy = (state_q != IDLE) | done_q;
    assign done = done_q;
    assign z    = z_q;

endmodule
